eth_gmii_tx: RTL and testbench



---
 rtl/eth_pkg.sv | 23 ++
 rtl/eth_crc32_byte.sv | 23 ++
 rtl/eth_gmii_tx.sv | 163 ++++++++++++++++
 tb/tb_eth_gmii_tx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared constants and state type for the GMII transmit/receive MAC path.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
    localparam int          ETH_MIN_FRAME     = 60;
    localparam int          ETH_IFG           = 12;

    // Transmit framer states; each state names the kind of byte chosen for the wire.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_SFD,
        TX_DATA,
        TX_PAD,
        TX_FCS,
        TX_ABORT,
        TX_IFG
    } tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: one byte step of the IEEE 802.3 CRC-32 (reflected, LSB first).
// Purely combinational so both the transmit framer and the receive FCS checker can use it.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Fold the byte into the low end, then shift out eight bits against the reflected polynomial.
    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0]) begin
                crc_out = (crc_out >> 1) ^ ETH_CRC_POLY_REFL;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_gmii_tx.sv
// eth_gmii_tx: AXI-Stream byte frames in, GMII transmit bytes out.
// Adds preamble/SFD, CRC-32 FCS and a fixed inter-frame gap; an input underrun inside a
// frame is signalled with one txer byte and the rest of that frame is discarded.
// Optional feature: define ETH_GMII_TX_PAD_EN to zero-pad runt frames to MIN_FRAME_BYTES.
// PREAMBLE_BYTES must be at least 2 (IDLE emits the first preamble byte itself).
module eth_gmii_tx
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = ETH_IFG
`ifdef ETH_GMII_TX_PAD_EN
    ,
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME
`endif
) (
    input  logic       clk,
    input  logic       sreset,
    output logic       axis_i_tready,
    input  logic       axis_i_tvalid,
    input  logic       axis_i_tlast,
    input  logic [7:0] axis_i_tdata,
    output logic [7:0] eth_txd,
    output logic       eth_txen,
    output logic       eth_txer
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);
`ifdef ETH_GMII_TX_PAD_EN
    localparam logic [7:0] MIN_CNT  = 8'(MIN_FRAME_BYTES);
`endif

    tx_state_t   state;
    logic [7:0]  cnt;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [7:0]  crc_data;
`ifdef ETH_GMII_TX_PAD_EN
    logic [7:0]  byte_cnt;
`endif

    assign axis_i_tready = (state == TX_DATA) || (state == TX_ABORT);

    // Payload bytes feed the CRC in DATA; pad bytes are zeros.
    always_comb begin
        crc_data = (state == TX_DATA) ? axis_i_tdata : 8'h00;
    end

    eth_crc32_byte u_crc (
        .crc_in  (crc),
        .data    (crc_data),
        .crc_out (crc_next)
    );

    // Framer FSM: each state picks the next wire byte, which the output registers present one cycle later.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state    <= TX_IDLE;
            cnt      <= 8'd0;
            crc      <= ETH_CRC_INIT;
            eth_txd  <= 8'h00;
            eth_txen <= 1'b0;
            eth_txer <= 1'b0;
`ifdef ETH_GMII_TX_PAD_EN
            byte_cnt <= 8'd0;
`endif
        end else begin
            eth_txd  <= 8'h00;
            eth_txen <= 1'b0;
            eth_txer <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (axis_i_tvalid) begin
                        eth_txd  <= ETH_PREAMBLE_BYTE;
                        eth_txen <= 1'b1;
                        cnt      <= 8'd1;
                        crc      <= ETH_CRC_INIT;
`ifdef ETH_GMII_TX_PAD_EN
                        byte_cnt <= 8'd0;
`endif
                        state    <= TX_PREAMBLE;
                    end
                end
                TX_PREAMBLE: begin
                    eth_txd  <= ETH_PREAMBLE_BYTE;
                    eth_txen <= 1'b1;
                    cnt      <= cnt + 8'd1;
                    if (cnt == PRE_LAST) begin
                        cnt   <= 8'd0;
                        state <= TX_SFD;
                    end
                end
                TX_SFD: begin
                    eth_txd  <= ETH_SFD_BYTE;
                    eth_txen <= 1'b1;
                    state    <= TX_DATA;
                end
                TX_DATA: begin
                    eth_txen <= 1'b1;
                    if (axis_i_tvalid) begin
                        eth_txd <= axis_i_tdata;
                        crc     <= crc_next;
`ifdef ETH_GMII_TX_PAD_EN
                        if (byte_cnt != MIN_CNT) begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
`endif
                        if (axis_i_tlast) begin
                            cnt   <= 8'd0;
                            state <= TX_FCS;
`ifdef ETH_GMII_TX_PAD_EN
                            if ((byte_cnt + 8'd1) < MIN_CNT) begin
                                state <= TX_PAD;
                            end
`endif
                        end
                    end else begin
                        eth_txer <= 1'b1;
                        state    <= TX_ABORT;
                    end
                end
`ifdef ETH_GMII_TX_PAD_EN
                TX_PAD: begin
                    eth_txen <= 1'b1;
                    crc      <= crc_next;
                    byte_cnt <= byte_cnt + 8'd1;
                    if ((byte_cnt + 8'd1) == MIN_CNT) begin
                        cnt   <= 8'd0;
                        state <= TX_FCS;
                    end
                end
`endif
                TX_FCS: begin
                    eth_txd  <= ~crc[7:0];
                    eth_txen <= 1'b1;
                    crc      <= {8'h00, crc[31:8]};
                    cnt      <= cnt + 8'd1;
                    if (cnt == 8'd3) begin
                        cnt   <= 8'd0;
                        state <= TX_IFG;
                    end
                end
                TX_ABORT: begin
                    if (axis_i_tvalid && axis_i_tlast) begin
                        cnt   <= 8'd0;
                        state <= TX_IFG;
                    end
                end
                TX_IFG: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == IFG_LAST) begin
                        cnt   <= 8'd0;
                        state <= TX_IDLE;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_gmii_tx.sv
// tb_eth_gmii_tx: self-checking bench for eth_gmii_tx.
// Frames are driven over AXI-Stream; every GMII cycle is logged and compared against a
// frame-level model (preamble, payload, optional pad, software CRC-32, gap rules).
// Honours ETH_GMII_TX_PAD_EN the same way the design does.
module tb_eth_gmii_tx;

    logic       clk = 1'b0;
    logic       sreset;
    logic       tready;
    logic       tvalid;
    logic       tlast;
    logic [7:0] tdata;
    logic [7:0] txd;
    logic       txen;
    logic       txer;

    eth_gmii_tx dut (
        .clk           (clk),
        .sreset        (sreset),
        .axis_i_tready (tready),
        .axis_i_tvalid (tvalid),
        .axis_i_tlast  (tlast),
        .axis_i_tdata  (tdata),
        .eth_txd       (txd),
        .eth_txen      (txen),
        .eth_txer      (txer)
    );

    // 125 MHz GMII clock.
    always #4 clk = ~clk;

    int cyc = 0;
    int check_count = 0;
    int error_count = 0;

    // Cycle index shared by the driver and the wire log.
    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] wire_log [int];

    // Record every cycle's wire state away from the active edge.
    always @(negedge clk) wire_log[cyc] = {tready, txer, txen, txd};

    logic [7:0] exp_bytes [$];
    int         exp_lens  [$];
    bit         exp_abort [$];
    int         exp_tlast [$];
    int         batch_lo;
    int         batch_first;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Serial bit-at-a-time CRC-32 over the frame body, returned already inverted.
    function automatic logic [31:0] refFcs(input logic [7:0] body [$]);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        foreach (body[i]) begin
            b = body[i];
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic addExpected(input logic [7:0] payload [$], input int underrun_k, input int tlast_cyc);
        logic [7:0]  body [$];
        logic [31:0] fcs;
        logic [31:0] sh;
        int          n0;
        n0 = exp_bytes.size();
        for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        if (underrun_k >= 0) begin
            for (int i = 0; i < underrun_k; i++) exp_bytes.push_back(payload[i]);
            exp_bytes.push_back(8'h00);
        end else begin
            body = payload;
`ifdef ETH_GMII_TX_PAD_EN
            while (body.size() < 60) body.push_back(8'h00);
`endif
            fcs = refFcs(body);
            foreach (body[i]) exp_bytes.push_back(body[i]);
            for (int i = 0; i < 4; i++) begin
                sh = fcs >> (8 * i);
                exp_bytes.push_back(sh[7:0]);
            end
        end
        exp_lens.push_back(exp_bytes.size() - n0);
        exp_abort.push_back(underrun_k >= 0);
        exp_tlast.push_back(tlast_cyc);
    endtask

    task automatic applyStimulus(input logic [7:0] payload [$], input int underrun_k, input int gap_cycles,
                                 output int first_cyc, output int tlast_cyc);
        int i;
        int gap_left;
        int guard;
        bit started;
        i = 0;
        gap_left = gap_cycles;
        guard = 0;
        started = 0;
        first_cyc = -1;
        tlast_cyc = -1;
        while (i < payload.size()) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                checkOutput("driverTimeout", 1, 0);
                break;
            end
            if (i == underrun_k && gap_left > 0) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                gap_left--;
            end else begin
                tvalid = 1'b1;
                tdata  = payload[i];
                tlast  = (i == payload.size() - 1);
                if (!started) begin
                    first_cyc = cyc;
                    started = 1;
                end
                if (tready) begin
                    if (tlast) tlast_cyc = cyc;
                    i++;
                end
            end
        end
    endtask

    task automatic runFrame(input logic [7:0] payload [$], input int underrun_k, input int gap_cycles,
                            output int first_cyc);
        int tl;
        applyStimulus(payload, underrun_k, gap_cycles, first_cyc, tl);
        if (batch_first < 0) batch_first = first_cyc;
        addExpected(payload, underrun_k, tl);
    endtask

    task automatic beginBatch();
        batch_lo = cyc;
        batch_first = -1;
    endtask

    // Split the logged window into txen-high runs and compare them with the model.
    task automatic checkWindow(input int lo, input int hi, input int first);
        int          run_start [$];
        int          run_len   [$];
        int          run_txer  [$];
        logic [7:0]  run_bytes [$];
        logic [10:0] e;
        int          idle_txer;
        int          n;
        int          a_off;
        int          e_off;
        int          m;
        int          busy;
        bit          in_run;
        idle_txer = 0;
        in_run = 0;
        for (int k = lo; k < hi; k++) begin
            e = wire_log.exists(k) ? wire_log[k] : 11'h000;
            if (e[8]) begin
                if (!in_run) begin
                    run_start.push_back(k);
                    run_len.push_back(0);
                    run_txer.push_back(0);
                    in_run = 1;
                end
                run_len[run_len.size() - 1] += 1;
                if (e[9]) run_txer[run_txer.size() - 1] += 1;
                run_bytes.push_back(e[7:0]);
            end else begin
                in_run = 0;
                if (e[9]) idle_txer++;
            end
        end
        checkOutput("idleTxer", idle_txer, 0);
        checkOutput("runCount", run_start.size(), exp_lens.size());
        if (run_start.size() > 0 && first >= 0) checkOutput("startLatency", run_start[0] - first, 1);
        n = (run_start.size() < exp_lens.size()) ? run_start.size() : exp_lens.size();
        a_off = 0;
        e_off = 0;
        for (int r = 0; r < n; r++) begin
            checkOutput($sformatf("runLen[%0d]", r), run_len[r], exp_lens[r]);
            m = (run_len[r] < exp_lens[r]) ? run_len[r] : exp_lens[r];
            for (int j = 0; j < m; j++) begin
                checkOutput($sformatf("txd[%0d.%0d]", r, j), run_bytes[a_off + j], exp_bytes[e_off + j]);
            end
            checkOutput($sformatf("txerCount[%0d]", r), run_txer[r], exp_abort[r] ? 1 : 0);
            if (exp_abort[r]) begin
                e = wire_log[run_start[r] + run_len[r] - 1];
                checkOutput("abortTxer", e[9], 1);
            end
            if (r < n - 1) begin
                if (exp_abort[r]) checkOutput("abortGap", run_start[r + 1] - exp_tlast[r], 14);
                else checkOutput("ifgGap", run_start[r + 1] - (run_start[r] + run_len[r]), 12);
                busy = 0;
                for (int k = run_start[r + 1] - 12; k < run_start[r + 1]; k++) begin
                    e = wire_log[k];
                    if (e[10]) busy++;
                end
                checkOutput("ifgTready", busy, 0);
            end
            a_off += run_len[r];
            e_off += exp_lens[r];
        end
    endtask

    task automatic endBatch();
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (100) @(negedge clk);
        checkWindow(batch_lo, cyc, batch_first);
        exp_bytes.delete();
        exp_lens.delete();
        exp_abort.delete();
        exp_tlast.delete();
    endtask

    task automatic randomPayload(input int len, output logic [7:0] p [$]);
        p.delete();
        for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
    endtask

    logic [7:0] pay [$];
    logic [7:0] pay2 [$];
    logic [7:0] lit [4];
    logic [10:0] ent;
    int fc;
    int len;
    int uk;
    int acc;
    int guard;

    initial begin
        sreset = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("resetTxd", txd, 8'h00);
        checkOutput("resetTxen", txen, 0);
        checkOutput("resetTxer", txer, 0);
        checkOutput("resetTready", tready, 0);
        sreset = 1'b0;
        repeat (2) @(negedge clk);

        // Standard check string "123456789".
        beginBatch();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        runFrame(pay, -1, 0, fc);
        endBatch();
`ifndef ETH_GMII_TX_PAD_EN
        lit = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int b = 0; b < 4; b++) begin
            ent = wire_log[fc + 1 + 17 + b];
            checkOutput($sformatf("fcsLiteral[%0d]", b), ent[7:0], lit[b]);
        end
        ent = wire_log[fc + 1 + 21];
        checkOutput("txenAfterFcs", ent[8], 0);
`endif

        // Single-byte runt, then a 64-byte frame 0x00..0x3F, back to back.
        beginBatch();
        pay.delete();
        pay.push_back(8'hAB);
        runFrame(pay, -1, 0, fc);
        pay.delete();
        for (int i = 0; i < 64; i++) pay.push_back(8'(i));
        runFrame(pay, -1, 0, fc);
        endBatch();

        // Underrun after byte 10 for 3 cycles, then a normal frame.
        beginBatch();
        randomPayload(16, pay);
        runFrame(pay, 10, 3, fc);
        randomPayload(20, pay);
        runFrame(pay, -1, 0, fc);
        endBatch();

        // Random back-to-back frames with occasional underruns.
        beginBatch();
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 80);
            randomPayload(len, pay);
            uk = -1;
            if (len >= 2 && $urandom_range(0, 3) == 0) uk = $urandom_range(1, len - 1);
            runFrame(pay, uk, $urandom_range(1, 3), fc);
        end
        endBatch();

        // Reset while byte 20 of a frame is on the input.
        randomPayload(30, pay);
        acc = 0;
        guard = 0;
        while (acc < 19 && guard < 200) begin
            @(negedge clk);
            guard++;
            tvalid = 1'b1;
            tdata  = pay[acc];
            tlast  = 1'b0;
            if (tready) acc++;
        end
        checkOutput("preResetAccepted", acc, 19);
        @(negedge clk);
        tdata  = pay[19];
        sreset = 1'b1;
        @(negedge clk);
        checkOutput("midResetTxd", txd, 8'h00);
        checkOutput("midResetTxen", txen, 0);
        checkOutput("midResetTxer", txer, 0);
        checkOutput("midResetTready", tready, 0);
        sreset = 1'b0;
        tvalid = 1'b0;
        beginBatch();
        randomPayload(25, pay2);
        runFrame(pay2, -1, 0, fc);
        endBatch();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
